// File: rtl/hex_7seg_display_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hex_7seg_pkg
// Shared types and helpers for the hex 7-segment display controller.
//   SEG_BLANK : all segments off (active-low encoding)
//   seg_t     : one digit's segments, bit order {g,f,e,d,c,b,a}, active-low
//   hex2seg   : nibble -> active-low segment pattern
// ----------------------------------------------------------------------------
package hex_7seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Lower-case b and d keep those digits distinguishable from 8 and 0.
  function automatic seg_t hex2seg(input logic [3:0] nibble);
    seg_t seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_7seg_digit_enc.sv
// ----------------------------------------------------------------------------
// hex_7seg_digit_enc
// Combinational encoder for a single digit.
//   i_nibble : hex value of this digit
//   i_blank  : 1 forces the digit dark regardless of its value
//   o_seg    : active-low segments {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module hex_7seg_digit_enc
  import hex_7seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output seg_t       o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : hex2seg(i_nibble);

endmodule

// File: rtl/hex_7seg_display_ctrl.sv
// ----------------------------------------------------------------------------
// hex_7seg_display_ctrl
// Multi-digit hex to 7-segment controller. Captures a hex word on a load
// strobe and drives a registered, active-low parallel segment bus with
// per-digit blink, leading-zero suppression and a global enable.
//
// Optional macro HEX_7SEG_SCAN_EN builds a time-multiplexed scan output for
// common-anode displays; without it o_seg / o_dig_sel idle at all ones.
//
// Ports:
//   i_clk         : system clock
//   i_rst_n       : asynchronous active-low reset
//   i_en_hex      : 0 blanks every digit (live)
//   i_load        : 1-cycle strobe capturing i_data
//   i_data        : hex word, nibble k -> digit k, digit 0 least significant
//   i_lz_suppress : 1 blanks leading zero digits (digit 0 always shown)
//   i_blink_mask  : bit k makes digit k blink
//   o_hex_bus     : parallel segments, slice k is digit k
//   o_seg         : scanned segment output
//   o_dig_sel     : scanned one-hot active-low digit select
// ----------------------------------------------------------------------------
module hex_7seg_display_ctrl
  import hex_7seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SIZE_7SEG  = 7,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_en_hex,
  input  logic                            i_load,
  input  logic [4*NUM_DIGITS-1:0]         i_data,
  input  logic                            i_lz_suppress,
  input  logic [NUM_DIGITS-1:0]           i_blink_mask,
  output logic [SIZE_7SEG*NUM_DIGITS-1:0] o_hex_bus,
  output logic [SIZE_7SEG-1:0]            o_seg,
  output logic [NUM_DIGITS-1:0]           o_dig_sel
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [4*NUM_DIGITS-1:0]         data_q, data_d;
  logic [BLINK_W-1:0]              blink_cnt_q, blink_cnt_d;
  logic                            blink_phase_q, blink_phase_d;
  logic [SIZE_7SEG*NUM_DIGITS-1:0] hex_bus_q, hex_bus_d;
  logic [NUM_DIGITS-1:0]           lz_blank;
  logic [NUM_DIGITS-1:0]           digit_blank;
  seg_t                            enc_seg [NUM_DIGITS];

  always_comb begin
    data_d = i_load ? i_data : data_q;
  end

  // Free-running blink timebase; the phase flips each time the counter wraps.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Walk from the most significant digit down; a digit is a leading zero while
  // it and everything above it are zero. Digit 0 stays visible so a zero word
  // still shows a single 0.
  always_comb begin
    logic zeros_so_far;
    zeros_so_far = 1'b1;
    lz_blank     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zeros_so_far = zeros_so_far & (data_q[4*k +: 4] == 4'h0);
      if (k != 0) begin
        lz_blank[k] = i_lz_suppress & zeros_so_far;
      end
    end
  end

  always_comb begin
    digit_blank = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_blank[k] = ~i_en_hex | lz_blank[k] | (i_blink_mask[k] & blink_phase_q);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex_7seg_digit_enc u_enc (
      .i_nibble (data_q[4*g +: 4]),
      .i_blank  (digit_blank[g]),
      .o_seg    (enc_seg[g])
    );
  end

  always_comb begin
    hex_bus_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      hex_bus_d[SIZE_7SEG*k +: SIZE_7SEG] = enc_seg[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      hex_bus_q     <= '1;
    end else begin
      data_q        <= data_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      hex_bus_q     <= hex_bus_d;
    end
  end

  assign o_hex_bus = hex_bus_q;

`ifdef HEX_7SEG_SCAN_EN

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic [SIZE_7SEG-1:0]  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

  // Segment and select are taken from the next-state index and the bus value
  // being registered this edge, so both always match o_hex_bus at the digit
  // currently selected.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end
    seg_d                 = hex_bus_d[SIZE_7SEG*scan_idx_d +: SIZE_7SEG];
    dig_sel_d             = '1;
    dig_sel_d[scan_idx_d] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= '1;
      dig_sel_q  <= '1;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign o_seg     = seg_q;
  assign o_dig_sel = dig_sel_q;

`else

  assign o_seg     = '1;
  assign o_dig_sel = '1;

`endif

endmodule

// File: tb/tb_hex_7seg_display_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hex_7seg_display_ctrl
// Directed self-checking bench for hex_7seg_display_ctrl with 4 digits,
// blink divider 4 and scan divider 3. Scan expectations follow
// HEX_7SEG_SCAN_EN; without it the scan outputs must idle at all ones.
// ----------------------------------------------------------------------------
module tb_hex_7seg_display_ctrl;

  localparam int NUM_DIGITS = 4;
  localparam int SIZE_7SEG  = 7;
  localparam int BLINK_DIV  = 4;
  localparam int SCAN_DIV   = 3;

  logic        clk;
  logic        rst_n;
  logic        en_hex;
  logic        load;
  logic [15:0] data;
  logic        lz_suppress;
  logic [3:0]  blink_mask;
  logic [27:0] hex_bus;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;

  int num_compared;
  int num_mismatched;
  int edge_cnt;

  hex_7seg_display_ctrl #(
    .NUM_DIGITS (NUM_DIGITS),
    .SIZE_7SEG  (SIZE_7SEG),
    .BLINK_DIV  (BLINK_DIV),
    .SCAN_DIV   (SCAN_DIV)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en_hex      (en_hex),
    .i_load        (load),
    .i_data        (data),
    .i_lz_suppress (lz_suppress),
    .i_blink_mask  (blink_mask),
    .o_hex_bus     (hex_bus),
    .o_seg         (seg),
    .o_dig_sel     (dig_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since the last reset release; blink and scan timing are
  // both simple functions of this count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [27:0] bus4(input logic [6:0] s3, input logic [6:0] s2,
                                       input logic [6:0] s1, input logic [6:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic en,
                               input logic lz, input logic [3:0] mask);
    load        = ld;
    data        = d;
    en_hex      = en;
    lz_suppress = lz;
    blink_mask  = mask;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the scan outputs against the digit the scanner should be on.
  task automatic checkScan(input string tag, input logic [27:0] exp_bus);
    logic [3:0] exp_dig;
    logic [6:0] exp_seg;
`ifdef HEX_7SEG_SCAN_EN
    int idx;
    idx     = (edge_cnt / SCAN_DIV) % NUM_DIGITS;
    exp_dig = 4'hF ^ (4'b0001 << idx);
    exp_seg = exp_bus[7*idx +: 7];
`else
    exp_dig = 4'hF;
    exp_seg = 7'h7F;
`endif
    checkOutput({tag, "_dig_sel"}, {28'd0, dig_sel}, {28'd0, exp_dig});
    checkOutput({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg});
  endtask

  initial begin
    logic [27:0] exp_bus;
    logic        ph;
    num_compared   = 0;
    num_mismatched = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000);

    // Reset state, both while held and right after release.
    #12;
    checkOutput("rst_bus", {4'd0, hex_bus}, {4'd0, 28'hFFFFFFF});
    checkOutput("rst_dig_sel", {28'd0, dig_sel}, 32'h0000000F);
    checkOutput("rst_seg", {25'd0, seg}, 32'h0000007F);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rel_bus", {4'd0, hex_bus}, {4'd0, 28'hFFFFFFF});
    checkOutput("rel_dig_sel", {28'd0, dig_sel}, 32'h0000000F);

    // Basic load and encode, 1 cycle after capture.
    applyStimulus(1'b1, 16'h12AF, 1'b1, 1'b0, 4'b0000);
    tick();
    applyStimulus(1'b0, 16'hFFFF, 1'b1, 1'b0, 4'b0000);
    tick();
    exp_bus = bus4(7'h79, 7'h24, 7'h08, 7'h0E);
    checkOutput("load_12AF", {4'd0, hex_bus}, {4'd0, exp_bus});
    tick();
    tick();
    checkOutput("hold_12AF", {4'd0, hex_bus}, {4'd0, exp_bus});

    // Leading-zero suppression.
    applyStimulus(1'b1, 16'h0070, 1'b1, 1'b1, 4'b0000);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000);
    tick();
    checkOutput("lz_0070", {4'd0, hex_bus}, {4'd0, bus4(7'h7F, 7'h7F, 7'h78, 7'h40)});
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000);
    tick();
    checkOutput("nolz_0070", {4'd0, hex_bus}, {4'd0, bus4(7'h40, 7'h40, 7'h78, 7'h40)});
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1, 4'b0000);
    tick();
    applyStimulus(1'b0, 16'h5555, 1'b1, 1'b1, 4'b0000);
    tick();
    checkOutput("lz_0000", {4'd0, hex_bus}, {4'd0, bus4(7'h7F, 7'h7F, 7'h7F, 7'h40)});
    applyStimulus(1'b1, 16'h1004, 1'b1, 1'b1, 4'b0000);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000);
    tick();
    checkOutput("lz_1004", {4'd0, hex_bus}, {4'd0, bus4(7'h79, 7'h40, 7'h40, 7'h19)});

    // Blink on digit 0: dark while the phase sampled at the edge was 1.
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0, 4'b0001);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 4'b0001);
    tick();
    for (int i = 0; i < 10; i++) begin
      ph      = (((edge_cnt - 1) / BLINK_DIV) % 2) == 1;
      exp_bus = bus4(7'h79, 7'h24, 7'h30, ph ? 7'h7F : 7'h19);
      checkOutput($sformatf("blink_%0d", i), {4'd0, hex_bus}, {4'd0, exp_bus});
      tick();
    end

    // Enable dropped together with a load: dark, but new data retained.
    applyStimulus(1'b1, 16'h5678, 1'b0, 1'b0, 4'b0001);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000);
    tick();
    checkOutput("en_off", {4'd0, hex_bus}, {4'd0, 28'hFFFFFFF});
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000);
    tick();
    checkOutput("en_on_5678", {4'd0, hex_bus}, {4'd0, bus4(7'h12, 7'h02, 7'h78, 7'h00)});

    // Scan walk over a stable value.
    applyStimulus(1'b1, 16'h12AF, 1'b1, 1'b0, 4'b0000);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000);
    tick();
    exp_bus = bus4(7'h79, 7'h24, 7'h08, 7'h0E);
    for (int i = 0; i < 14; i++) begin
      checkScan($sformatf("scan_%0d", i), exp_bus);
      tick();
    end

    // Asynchronous reset mid-scan, then restart from digit 0.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_bus", {4'd0, hex_bus}, {4'd0, 28'hFFFFFFF});
    checkOutput("arst_dig_sel", {28'd0, dig_sel}, 32'h0000000F);
    checkOutput("arst_seg", {25'd0, seg}, 32'h0000007F);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_bus = bus4(7'h40, 7'h40, 7'h40, 7'h40);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("post_rst_bus_%0d", i), {4'd0, hex_bus}, {4'd0, exp_bus});
      checkScan($sformatf("post_rst_%0d", i), exp_bus);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
